// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmitter and the uart_simple receiver.
// Holds the frame geometry, the line levels for mark and start, the
// transmitter FSM state encoding and a helper that assembles a frame.
// No ports; imported with "import uart_pkg::*;".
package uart_pkg;

    localparam int UART_FRAME_BITS = 12;
    localparam int UART_DATA_LSB   = 2;
    localparam int UART_DATA_MSB   = 9;

    localparam logic MARK  = 1'b1;
    localparam logic START = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } uart_state_e;

    // Builds the on-wire frame with bit 0 being the first bit sent:
    // mark, start, D0..D7, then two stop bits (mark level).
    function automatic logic [UART_FRAME_BITS-1:0] uartBuildFrame(input logic [7:0] data);
        logic [UART_FRAME_BITS-1:0] frame;
        frame = {UART_FRAME_BITS{MARK}};
        frame[0] = MARK;
        frame[1] = START;
        frame[UART_DATA_MSB:UART_DATA_LSB] = data;
        return frame;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Baud-rate divider for the UART transmitter. Counts clk cycles from 0 to
// CLKS_PER_BIT-1 and raises tick for the single cycle the count sits at its
// terminal value, then wraps. Same clock domain as everything else.
// Ports:
//   clk    in  1  system clock
//   btn0   in  1  synchronous active-high reset
//   clear  in  1  holds the count at zero while high
//   tick   out 1  one-cycle enable at terminal count
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic btn0,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // tick is decoded from the registered count, so it is glitch-free and
    // lines up with the last cycle of each bit period.
    assign tick = (count_q == LAST_COUNT);

    // Wrap on terminal count; clear forces the next bit period to start at
    // zero so the first bit of a frame gets its full length.
    always_comb begin
        count_d = count_q + CW'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (btn0) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter
// Serialises one byte into the 12-bit frame expected by the uart_simple
// receiver: mark, start, D0..D7 (LSB first), two stop bits. Each bit is
// held for CLKS_PER_BIT clk cycles. All outputs are registered.
// Ports:
//   clk              in   1  system clock
//   btn0             in   1  synchronous active-high reset
//   tx_start         in   1  request to send tx_data
//   tx_data          in   8  byte to send, captured when tx_start is accepted
//   onebit_data_out  out  1  serial line, idles high
//   tx_busy          out  1  high while a frame is on the line
//   tx_done          out  1  one-cycle pulse after the last stop bit
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       btn0,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       onebit_data_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int FRAME_BITS = UART_FRAME_BITS;
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    uart_state_e           state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]            bitIdx_q, bitIdx_d;
    logic                  line_q, line_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  baudClear;
    logic                  baudTick;

    // The divider only runs while a frame is being sent; in IDLE and DONE it
    // is held at zero so the next frame starts with a full-length bit.
    assign baudClear = (state_q != S_SEND);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .btn0  (btn0),
        .clear (baudClear),
        .tick  (baudTick)
    );

    // Next-state logic. DONE accepts a new request just like IDLE, which is
    // what gives back-to-back frames with a single high cycle between them.
    // Outputs are computed from the next state so that they can be
    // registered and still line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitIdx_d = bitIdx_q;
        line_d   = MARK;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (tx_start) begin
                    shift_d  = uartBuildFrame(tx_data);
                    bitIdx_d = 4'd0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                if (baudTick) begin
                    if (bitIdx_q == LAST_BIT) begin
                        state_d = S_DONE;
                    end else begin
                        shift_d  = {MARK, shift_q[FRAME_BITS-1:1]};
                        bitIdx_d = bitIdx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_SEND: begin
                line_d = shift_d[0];
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                line_d = MARK;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (btn0) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bitIdx_q <= 4'd0;
            line_q   <= MARK;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitIdx_q <= bitIdx_d;
            line_q   <= line_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign onebit_data_out = line_q;
    assign tx_busy         = busy_q;
    assign tx_done         = done_q;

endmodule
